// File: rtl/dram_access_arbiter.sv
// Two-port round-robin arbiter and sequencer for the data DRAM.
// Checks range/alignment, drives the DRAM for one cycle, returns one response.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req*/addr*/wdata*/we*      per-port request and payload
//   width*/sign*               access size and load sign extension
//   gnt*, rvalid*              one-cycle accept / response pulses
//   rdata, err                 shared response data and error
//   mem_*                      registered DRAM command outputs
//   mem_rdata, mem_write_error DRAM read data and write range flag
module dram_access_arbiter #(
    parameter logic [31:0] BASE   = 32'h10010000,
    parameter int unsigned LENGTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  width0,
    input  logic [1:0]  width1,
    input  logic        sign0,
    input  logic        sign1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_ena,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_width,
    output logic        mem_sign,
    input  logic [31:0] mem_rdata,
    input  logic        mem_write_error
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    logic        cerr_q;

    logic        arb;
    logic        pick;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic [1:0]  sel_width;
    logic        sel_sign;
    logic        sel_err;

    function automatic logic access_err(input logic [31:0] a,
                                        input logic [1:0]  w);
        logic [32:0] n;
        logic [32:0] off;
        logic        range_e;
        logic        align_e;
        n       = w[1] ? 33'd4 : (w[0] ? 33'd2 : 33'd1);
        off     = {1'b0, a} - {1'b0, BASE};
        range_e = (a < BASE) || ((off + n) > 33'(LENGTH));
        align_e = (w[1] && (a[1:0] != 2'b00)) ||
                  (!w[1] && w[0] && a[0]);
        return range_e || align_e;
    endfunction

    // The check runs on the winner's payload at the sampling edge so that
    // mem_ena can itself be a register; the verdict is kept in cerr_q.
    always_comb begin
        state_d   = state_q;
        arb       = 1'b0;
        pick      = (req0 && req1) ? ~last_q : req1;
        sel_addr  = pick ? addr1  : addr0;
        sel_wdata = pick ? wdata1 : wdata0;
        sel_we    = pick ? we1    : we0;
        sel_width = pick ? width1 : width0;
        sel_sign  = pick ? sign1  : sign0;
        sel_err   = access_err(sel_addr, sel_width);
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    arb     = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (req0 || req1) begin
                    arb     = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            cerr_q    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= 32'h0;
            err       <= 1'b0;
            mem_ena   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_width <= 2'b00;
            mem_sign  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_ena <= 1'b0;
            mem_we  <= 1'b0;
            if (arb) begin
                owner_q   <= pick;
                last_q    <= pick;
                gnt0      <= ~pick;
                gnt1      <= pick;
                we_q      <= sel_we;
                cerr_q    <= sel_err;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_width <= sel_width;
                mem_sign  <= sel_sign;
                mem_ena   <= ~sel_err;
                mem_we    <= sel_we & ~sel_err;
            end
            if (state_q == ACCESS) begin
                rvalid0 <= ~owner_q;
                rvalid1 <= owner_q;
                err     <= cerr_q | (we_q & mem_write_error);
                rdata   <= (cerr_q || we_q) ? 32'h0 : mem_rdata;
            end
        end
    end

endmodule

// File: doc/dram_access_arbiter.md
Name: dram_access_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressed data DRAM.
- Port 0 is the pipeline MEM stage; port 1 is the secondary master (debug/DMA loader).
- Round-robin arbitration, range and alignment checks before any access reaches the DRAM, and one fixed-latency request/response protocol per port.

Parameters:
- BASE, 32'h10010000, first byte address of the DRAM window.
- LENGTH, 1024, DRAM size in bytes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1 each  request valid per port.
- addr0, addr1  in  32 each  byte address.
- wdata0, wdata1  in  32 each  store data, right-aligned.
- we0, we1  in  1 each  1 = store, 0 = load.
- width0, width1  in  2 each  access size: width[1]=1 word; else width[0]=1 half; else byte.
- sign0, sign1  in  1 each  sign-extend loads.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted.
- rvalid0, rvalid1  out  1 each  one-cycle pulse: response valid.
- rdata  out  32  load result, shared by both ports.
- err  out  1  response error, shared; qualified by rvalid0/rvalid1.
- mem_ena  out  1  DRAM enable.
- mem_addr  out  32  DRAM address (absolute, BASE-relative decode is inside the DRAM).
- mem_wdata  out  32  DRAM write data.
- mem_we  out  1  DRAM write enable.
- mem_width  out  2  DRAM access size.
- mem_sign  out  1  DRAM sign-extend.
- mem_rdata  in  32  DRAM combinational read data.
- mem_write_error  in  1  DRAM write-out-of-range flag.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state=IDLE; gnt*, rvalid*, err, mem_ena, mem_we = 0; rdata, mem_addr, mem_wdata = 0; mem_width = 0; mem_sign = 0; last = 1 (port 0 wins the first tie).
- Arbitration (IDLE, or RESP with a request pending):
  - Sample req0/req1 at the edge.
  - One requester: pick it.
  - Both requesting: pick the port != last.
  - Latch the picked port's addr/wdata/we/width/sign, set last=picked, pulse gnt[picked] in the following cycle.
- Requester handshake:
  - Hold req and payload stable until gnt is seen.
  - Payload is captured at the sampling edge, so the requester may change it during the gnt cycle.
  - Deassert req during the gnt cycle unless issuing a new request.
- Check (combinational on latched fields; n = access bytes 4/2/1):
  - range_err = addr < BASE or addr-BASE+n > LENGTH.
  - align_err = (word and addr[1:0]!=0) or (half and addr[0]!=0).
- ACCESS (exactly one cycle, gnt pulse high in it):
  - No error: mem_ena=1; mem_we=latched we; mem_* = latched fields. A store commits at the edge ending ACCESS. A load captures mem_rdata into rdata at that edge.
  - Error: mem_ena=0, mem_we=0, no DRAM side effect; rdata <= 0; err pending.
- RESP (one cycle):
  - rvalid[owner]=1.
  - err = range_err | align_err | (store and mem_write_error sampled at the end of ACCESS).
  - rdata holds the load result; 0 for stores.
- RESP exit: if any req is sampled high, go directly to ACCESS for the new winner; otherwise go to IDLE.
- Throughput is one access per 2 cycles.
- Latency: req sampled at edge E0 → gnt in cycle E0..E1 → rvalid in cycle E1..E2.
- mem_ena and mem_we are 1 only in ACCESS; all mem_* outputs are registered, with no combinational path from req to the DRAM.
- rdata and err hold their values until the next RESP.
- A request arriving during ACCESS is not sampled until the RESP edge.
- Reset asserted mid-ACCESS: mem_ena and mem_we drop immediately, the store is aborted, and no rvalid is issued.
- Reset asserted mid-RESP: the rvalid pulse is cut and state returns to IDLE.

Test Plan:
- Port 0 word store addr=32'h10010010, wdata=32'hDEADBEEF, then word load from the same address → gnt0 one cycle after the sampling edge; rvalid0 two cycles after the sampling edge; rdata=32'hDEADBEEF; err=0.
- Byte load signed from a byte holding 8'h80 at 32'h10010003 → rdata=32'hFFFFFF80. Same load unsigned → 32'h00000080.
- req0 and req1 both held continuously, one cycle after reset → grants alternate 0,1,0,1. Each port's rvalid follows its own gnt by 1 cycle, with 2-cycle spacing between accesses.
- Word store at 32'h10010002 (misaligned) and at 32'h100103FE (range, BASE+LENGTH−2) → mem_ena stays 0; err=1 with rvalid; the targeted DRAM bytes are unchanged.
- Half load at 32'h100103FE → legal, err=0.
- rst_n pulsed low during the ACCESS cycle of a word store → mem_ena drops immediately; a later load of that address returns its old value; no rvalid is issued for the aborted store.
